instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Single-outstanding instruction fetcher with a prefetch FIFO
//            feeding decode. FETCH_HALT_EN adds a halt-word detector.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int IMEM_ADDR_W = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [IMEM_ADDR_W-1:0] redirect_pc,
    output logic [31:0]            if_id_reg,
    output logic [IMEM_ADDR_W-1:0] if_pc,
    output logic                   if_valid
`ifdef FETCH_HALT_EN
    ,
    output logic                   halted
`endif
);

    localparam int               c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_DEPTH   = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_REQ  = 2'd1;
    localparam logic [1:0]       c_ST_DROP = 2'd2;

    logic [1:0]             r_state;
    logic [IMEM_ADDR_W-1:0] r_pc;
    logic [31:0]            r_fifo_data [FIFO_DEPTH];
    logic [IMEM_ADDR_W-1:0] r_fifo_pc   [FIFO_DEPTH];
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W:0]       r_count;
    logic                   r_imem_req;
    logic [IMEM_ADDR_W-1:0] r_imem_addr;
    logic [31:0]            r_if_id;
    logic [IMEM_ADDR_W-1:0] r_if_pc;
    logic                   r_if_valid;

    logic        w_pop;
    logic        w_push;
    logic        w_halt;
    logic        w_halted;
    logic        w_flush;
    logic [31:0] w_head_data;

    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_pop       = !redirect && !stall && (r_count != '0);

`ifdef FETCH_HALT_EN
    logic r_halted;

    // The halt word is consumed like any pop but never reaches decode.
    assign w_halt   = w_pop && (w_head_data == 32'hFFFF_FFFF);
    assign w_halted = r_halted;
    assign halted   = r_halted;

    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            r_halted <= 1'b0;
        end else if (w_halt) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_halt   = 1'b0;
    assign w_halted = 1'b0;
`endif

    assign w_push  = (r_state == c_ST_REQ) && imem_ack && !redirect && !w_halt;
    assign w_flush = redirect || w_halt;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_pc        <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_if_id     <= '0;
            r_if_pc     <= '0;
            r_if_valid  <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end

            if (w_flush) begin
                r_if_id    <= '0;
                r_if_valid <= 1'b0;
            end else if (w_pop) begin
                r_if_id    <= w_head_data;
                r_if_pc    <= r_fifo_pc[r_rd_ptr];
                r_if_valid <= 1'b1;
            end else if (!stall) begin
                r_if_id    <= '0;
                r_if_valid <= 1'b0;
            end

            // An abandoned request still owes one ack, which DROP absorbs.
            if (redirect) begin
                r_pc       <= redirect_pc;
                r_imem_req <= 1'b0;
                if (r_state == c_ST_IDLE || imem_ack) begin
                    r_state <= c_ST_IDLE;
                end else begin
                    r_state <= c_ST_DROP;
                end
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (!w_halted && !w_halt && (r_count < c_DEPTH)) begin
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= r_pc;
                            r_state     <= c_ST_REQ;
                        end
                    end
                    c_ST_REQ: begin
                        if (imem_ack) begin
                            r_imem_req <= 1'b0;
                            r_state    <= c_ST_IDLE;
                            if (!w_halt) r_pc <= r_pc + 1'b1;
                        end else if (w_halt) begin
                            r_imem_req <= 1'b0;
                            r_state    <= c_ST_DROP;
                        end
                    end
                    c_ST_DROP: begin
                        if (imem_ack) r_state <= c_ST_IDLE;
                    end
                    default: begin
                        r_imem_req <= 1'b0;
                        r_state    <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;
    assign if_id_reg = r_if_id;
    assign if_pc     = r_if_pc;
    assign if_valid  = r_if_valid;

endmodule
`default_nettype wire
